// File: rtl/float_result_queue_if.sv
// Handshake bundle between the float multiplier, the result queue and
// the result consumer.
interface float_result_queue_if #(
  parameter int FLOAT_SIZE = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLOAT_SIZE-1:0] in_data;
  logic                  in_overflow;
  logic                  in_underflow;
  logic                  in_inexact;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLOAT_SIZE-1:0] out_data;
  logic [2:0]            out_flags;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_overflow,
    input  in_underflow,
    input  in_inexact,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_flags
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_overflow,
    output in_underflow,
    output in_inexact,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_flags
  );
endinterface

// File: rtl/float_result_queue.sv
// FWFT result queue for the float multiplier with a sticky
// exception status word {overflow, underflow, inexact}.
module float_result_queue #(
  parameter int FLOAT_SIZE = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  float_result_queue_if.slave        q,
  output logic [2:0]                 status,
  input  logic                       clear_status,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = FLOAT_SIZE + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [2:0]    stat_q, stat_d;
  logic          empty, full;
  logic          push, pop;
  logic [2:0]    flags_in;
  logic [EW-1:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                 (wr_q[PW-1] != rd_q[PW-1]);

  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign push = q.in_valid & ~full;
  assign pop  = q.out_ready & ~empty;

  assign flags_in = {q.in_overflow, q.in_underflow, q.in_inexact};
  assign head     = mem_q[rd_q[AW-1:0]];

  assign q.out_data  = head[FLOAT_SIZE-1:0];
  assign q.out_flags = head[EW-1:FLOAT_SIZE];
  assign status      = stat_q;
  assign count       = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + PW'(1);
      pop && !push: cnt_d = cnt_q - PW'(1);
      default:      cnt_d = cnt_q;
    endcase
    // a flagged push wins over a clear so no exception is lost
    stat_d = (push ? flags_in : 3'b000) |
             (clear_status ? 3'b000 : stat_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      stat_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {flags_in, q.in_data};
  end
endmodule

// File: tb/tb_float_result_queue.sv
// Directed-vector bench for float_result_queue (FLOAT_SIZE=32,
// DEPTH=4): handshakes, ordering, wrap, sticky status, reset.
module tb_float_result_queue;
  logic       clk;
  logic       rst_n;
  logic [2:0] status;
  logic       clear_status;
  logic [2:0] count;
  int         n_chk;
  int         n_fail;

  float_result_queue_if #(.FLOAT_SIZE(32)) q_if ();

  float_result_queue #(.FLOAT_SIZE(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .q            (q_if),
    .status       (status),
    .clear_status (clear_status),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    q_if.in_valid     = 1'b0;
    q_if.in_data      = 32'h0;
    q_if.in_overflow  = 1'b0;
    q_if.in_underflow = 1'b0;
    q_if.in_inexact   = 1'b0;
    q_if.out_ready    = 1'b0;
    clear_status      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (q_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b exp 0", q_if.out_valid);
    end
    n_chk++;
    if (q_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b exp 1", q_if.in_ready);
    end
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count got %0d exp 0", count);
    end
    n_chk++;
    if (status !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status got %b exp 000", status);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'h3F80_0000;
    n_chk++;
    if (q_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass got %b exp 0", q_if.out_valid);
    end
    step();
    q_if.in_valid = 1'b0;
    n_chk++;
    if (q_if.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out_valid got %b exp 1", q_if.out_valid);
    end
    n_chk++;
    if (q_if.out_data !== 32'h3F80_0000) begin
      n_fail++;
      $display("FAIL single_data got %h exp 3f800000", q_if.out_data);
    end
    n_chk++;
    if (q_if.out_flags !== 3'b000 || status !== 3'b000) begin
      n_fail++;
      $display("FAIL single_flags got %b/%b exp 000/000",
               q_if.out_flags, status);
    end
    n_chk++;
    if (count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_count got %0d exp 1", count);
    end
    q_if.out_ready = 1'b1;
    step();
    q_if.out_ready = 1'b0;
    n_chk++;
    if (q_if.out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop got v=%b c=%0d exp v=0 c=0",
               q_if.out_valid, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 32'h4000_0000 + 32'(i);
      n_chk++;
      if (q_if.in_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL fill_in_ready[%0d] got %b exp %b",
                 i, q_if.in_ready, (i < 4));
      end
      step();
    end
    q_if.in_valid = 1'b0;
    n_chk++;
    if (count !== 3'd4 || q_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got c=%0d r=%b exp c=4 r=0",
               count, q_if.in_ready);
    end
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (q_if.out_data !== 32'h4000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL fill_order[%0d] got %h exp %h",
                 i, q_if.out_data, 32'h4000_0000 + 32'(i));
      end
      step();
    end
    q_if.out_ready = 1'b0;
    n_chk++;
    if (count !== 3'd0 || q_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drain got c=%0d v=%b exp c=0 v=0",
               count, q_if.out_valid);
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] exp_q [5];
    for (int i = 0; i < 4; i++) begin
      q_if.in_valid = 1'b1;
      q_if.in_data  = 32'h5000_0000 + 32'(i);
      exp_q[i]      = 32'h5000_0000 + 32'(i);
      step();
    end
    exp_q[4]       = 32'h5000_0004;
    q_if.in_data   = 32'h5000_0004;
    q_if.out_ready = 1'b1;
    n_chk++;
    if (q_if.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_no_pass got %b exp 0", q_if.in_ready);
    end
    step();
    q_if.out_ready = 1'b0;
    n_chk++;
    if (count !== 3'd3 || q_if.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_pop got c=%0d r=%b exp c=3 r=1",
               count, q_if.in_ready);
    end
    step();
    q_if.in_valid = 1'b0;
    n_chk++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fullpp_held_push got %0d exp 4", count);
    end
    q_if.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_chk++;
      if (q_if.out_data !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fullpp_order[%0d] got %h exp %h",
                 i, q_if.out_data, exp_q[i]);
      end
      step();
    end
    q_if.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    q_if.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_if.in_data = 32'h6000_0000 + 32'(i);
      step();
    end
    q_if.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      q_if.in_data = 32'h6000_0000 + 32'(k + 2);
      n_chk++;
      if (q_if.out_data !== 32'h6000_0000 + 32'(k) ||
          count !== 3'd2) begin
        n_fail++;
        $display("FAIL b2b[%0d] got %h c=%0d exp %h c=2", k,
                 q_if.out_data, count, 32'h6000_0000 + 32'(k));
      end
      step();
    end
    q_if.in_valid = 1'b0;
    for (int k = 10; k < 12; k++) begin
      n_chk++;
      if (q_if.out_data !== 32'h6000_0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL b2b_tail[%0d] got %h exp %h", k,
                 q_if.out_data, 32'h6000_0000 + 32'(k));
      end
      step();
    end
    q_if.out_ready = 1'b0;
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_empty got %0d exp 0", count);
    end
  endtask

  task automatic test_status();
    q_if.in_valid    = 1'b1;
    q_if.in_data     = 32'h7F80_0000;
    q_if.in_overflow = 1'b1;
    clear_status     = 1'b1;
    step();
    q_if.in_valid    = 1'b0;
    q_if.in_overflow = 1'b0;
    clear_status     = 1'b0;
    n_chk++;
    if (status !== 3'b100 || q_if.out_flags !== 3'b100) begin
      n_fail++;
      $display("FAIL status_set_vs_clear got %b/%b exp 100/100",
               status, q_if.out_flags);
    end
    step();
    n_chk++;
    if (status !== 3'b100) begin
      n_fail++;
      $display("FAIL status_sticky got %b exp 100", status);
    end
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    n_chk++;
    if (status !== 3'b000) begin
      n_fail++;
      $display("FAIL status_clear got %b exp 000", status);
    end
    q_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_if.in_data = 32'h1 + 32'(i);
      step();
    end
    q_if.in_inexact = 1'b1;
    step();
    q_if.in_valid   = 1'b0;
    q_if.in_inexact = 1'b0;
    n_chk++;
    if (status !== 3'b000 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL status_refused got %b c=%0d exp 000 c=4",
               status, count);
    end
    q_if.out_ready = 1'b1;
    repeat (4) step();
    q_if.out_ready    = 1'b0;
    q_if.in_valid     = 1'b1;
    q_if.in_data      = 32'h0000_0001;
    q_if.in_underflow = 1'b1;
    q_if.in_inexact   = 1'b1;
    step();
    q_if.in_valid     = 1'b0;
    q_if.in_underflow = 1'b0;
    q_if.in_inexact   = 1'b0;
    n_chk++;
    if (status !== 3'b011 || q_if.out_flags !== 3'b011) begin
      n_fail++;
      $display("FAIL status_unf_inx got %b/%b exp 011/011",
               status, q_if.out_flags);
    end
    q_if.out_ready = 1'b1;
    clear_status   = 1'b1;
    step();
    q_if.out_ready = 1'b0;
    clear_status   = 1'b0;
  endtask

  task automatic test_reset_mid();
    q_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_if.in_data = 32'h8000_0000 + 32'(i);
      step();
    end
    q_if.in_valid = 1'b0;
    n_chk++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL rstmid_pre got %0d exp 3", count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (q_if.out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b c=%0d exp v=0 c=0",
               q_if.out_valid, count);
    end
    step();
    rst_n         = 1'b1;
    step();
    q_if.in_valid = 1'b1;
    q_if.in_data  = 32'h0000_0007;
    step();
    q_if.in_valid = 1'b0;
    n_chk++;
    if (q_if.out_data !== 32'h7 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL rstmid_new got %h c=%0d exp 00000007 c=1",
               q_if.out_data, count);
    end
    q_if.out_ready = 1'b1;
    step();
    q_if.out_ready = 1'b0;
    n_chk++;
    if (q_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_only_one got %b exp 0", q_if.out_valid);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_single_push();
    test_fill();
    test_full_pop_push();
    test_back_to_back();
    test_status();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/float_result_queue.md
Name: float_result_queue

Overview:
- Downstream stage of the combinational float multiplier: captures each product and its overflow/underflow/inexact flags into a small FIFO with valid/ready handshakes on both sides.
- Keeps a sticky exception status register, in the style of an FP status word, across all accepted results until software clears it.
- Lets the multiplier's registered operand stage advance independently of the result consumer.

Parameters:
- FLOAT_SIZE, 32, bit-length of a stored float (32 or 64 in use).
- DEPTH, 4, number of entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  queue can accept; equals not full.
- in_data  in  FLOAT_SIZE  product from the multiplier.
- in_overflow  in  1  multiplier overflow flag.
- in_underflow  in  1  multiplier underflow flag.
- in_inexact  in  1  multiplier inexact flag.
- out_valid  out  1  head entry available; equals not empty.
- out_ready  in  1  consumer takes the head entry this cycle.
- out_data  out  FLOAT_SIZE  head entry float.
- out_flags  out  3  head entry flags {overflow, underflow, inexact}.
- status  out  3  sticky OR of the flags of all accepted entries since the last clear, same bit order as out_flags.
- clear_status  in  1  synchronous clear of status.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync-safe release):
  - rd/wr pointers = 0, count = 0, status = 0.
  - out_valid = 0, in_ready = 1.
  - out_data and out_flags read the stale storage at pointer 0; their value is don't-care while out_valid = 0. Storage is not cleared.
- Push: when in_valid & in_ready, {in_overflow, in_underflow, in_inexact, in_data} is written at wr_ptr on the clock edge, and wr_ptr increments.
- Pop: when out_valid & out_ready, rd_ptr increments.
- Read path is first-word-fall-through:
  - out_data and out_flags are combinational from storage[rd_ptr].
  - Data pushed into an empty queue appears with out_valid = 1 on the cycle after the push edge. Latency is 1 cycle; there is no same-cycle bypass.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally modulo 2*DEPTH.
  - Storage is indexed by the low bits.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with out_ready = 1: in_ready stays 0 that cycle (no pass-through). The pop happens and the push is refused; the producer holds in_valid/in_data per the handshake.
- Empty with in_valid = 1: the push happens and out_valid stays 0 that cycle.
- Neither pointer moves and no storage is written unless its handshake completes.
- While in_valid = 0, in_data and flags are ignored.
- Handshake rule: the producer must not drop in_valid or change in_data/flags until accepted. The consumer may toggle out_ready freely.
- status update, per bit, on each clock edge:
  - A push with that flag set sets the bit.
  - Otherwise clear_status clears it.
  - Otherwise the bit holds.
  - A clear in the same cycle as a flagged push leaves the bit at 1, so no exception is lost.
- Flags of refused pushes (in_valid with in_ready = 0) never reach status.
- Reset mid-operation discards all entries immediately: out_valid drops asynchronously and count goes to 0.

Test Plan:
- Reset, then push 0x3F800000 (1.0f) with flags 000 and out_ready = 0 → next cycle out_valid = 1, out_data = 0x3F800000, out_flags = 000, count = 1, status = 000.
- DEPTH = 4, push 5 values 0x40000000..0x40000004 back-to-back with out_ready = 0 → 4 accepted, in_ready = 0 after the 4th, count = 4; pop all → data in order 0x40000000..0x40000003.
- Full queue, in_valid = 1 and out_ready = 1 for one cycle → one pop, no push, count = 3; next cycle the held push is accepted, count = 4.
- Count = 2, simultaneous push and pop for 10 cycles → count stays 2, data in order, pointers wrap past 2*DEPTH without corruption.
- Push an entry with overflow = 1 in the same cycle as clear_status = 1 → status = 100. Then clear_status alone → 000. A refused push carrying inexact = 1 → status stays 000.
- Reset asserted with 3 entries queued → out_valid = 0 and count = 0 without a clock edge. After release, a single push returns only the new value.
